// File: rtl/syn_counter_pkg.sv
// Shared types and constants for the syn_counter family: per-edge action
// encoding, direction constant and the parameter legality check.
package syn_counter_pkg;

  // Action taken on a clock edge, listed lowest to highest priority
  typedef enum logic [2:0] {
    ACT_HOLD  = 3'd0,
    ACT_COUNT = 3'd1,
    ACT_LOAD  = 3'd2,
    ACT_CLR   = 3'd3,
    ACT_SET   = 3'd4
  } action_t;

  // Direction input value meaning "count up"
  localparam logic DIR_UP = 1'b1;

  // Legal parameter set: 2 <= WIDTH <= 31, 2 <= MODULUS <= 2**WIDTH,
  // 0 <= RESET_VAL < MODULUS. The span is computed in 64 bits so the
  // check itself cannot overflow for any width it accepts.
  function automatic bit params_ok(input int width, input int modulus,
                                   input int reset_val);
    longint span;
    if (width < 2 || width > 31) return 1'b0;
    span = longint'(1) << width;
    if (modulus < 2) return 1'b0;
    if (longint'(modulus) > span) return 1'b0;
    if ($clog2(modulus) > width) return 1'b0;
    if (reset_val < 0 || reset_val >= modulus) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/syn_counter_term.sv
// Terminal-count detector: high when the next count in the current
// direction would wrap (top of range going up, zero going down).
module syn_counter_term
  import syn_counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic             term
);

  // Compared one bit wider so MODULUS = 2**WIDTH needs no special case
  localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0] q_ext;

  assign q_ext = {1'b0, q};

  // Pick the terminal value for the active direction
  always_comb begin
    term = 1'b0;
    if (up == DIR_UP) term = (q_ext == TOP);
    else              term = (q_ext == '0);
  end

endmodule

// File: rtl/syn_counter_mod.sv
// Parametrised synchronous modulo counter: up/down, wrap or saturate,
// parallel load, synchronous set/clear, cascade carry and a sticky
// overflow flag. Instances chain by feeding TC into the next CI.
module syn_counter_mod
  import syn_counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MODULUS   = 256,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             CI,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             SSET,
  input  logic             SCLR,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             TC_R,
  output logic             OVF
);

  // Refuse to elaborate with an illegal parameter set
  if (!params_ok(WIDTH, MODULUS, RESET_VAL)) begin : g_param_err
    $error("syn_counter_mod: illegal WIDTH/MODULUS/RESET_VAL");
  end

  // Range limits kept one bit wider than Q so the full-range modulus
  // compares and steps without a spurious carry out of WIDTH bits
  localparam logic [WIDTH:0]   TOP   = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  action_t          act;
  logic             term;
  logic             cnt_en;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   step;
  logic [WIDTH-1:0] wrap_q;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_r_nxt;
  logic             ovf_nxt;

  syn_counter_term #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_term (
    .q    (Q),
    .up   (UP),
    .term (term)
  );

  assign cnt_en = EN & CI;
  assign q_ext  = {1'b0, Q};
  assign d_ext  = {1'b0, D};

  // Carry out is live in the same cycle so a chained stage sees it
  // before the shared clock edge
  assign TC = term & cnt_en;

  // Resolve the single winning action: SSET > SCLR > LOAD > count > hold
  always_comb begin
    act = ACT_HOLD;
    if (SSET)        act = ACT_SET;
    else if (SCLR)   act = ACT_CLR;
    else if (LOAD)   act = ACT_LOAD;
    else if (cnt_en) act = ACT_COUNT;
  end

  // One-step move in the current direction; stepping past either end
  // lands outside 0..TOP in the widened arithmetic and selects the wrap
  always_comb begin
    step   = (UP == DIR_UP) ? (q_ext + 1'b1) : (q_ext - 1'b1);
    wrap_q = (UP == DIR_UP) ? '0 : MAX_Q;
  end

  // Next-state for count, pulse and sticky flag from the chosen action
  always_comb begin
    q_nxt    = Q;
    tc_r_nxt = 1'b0;
    ovf_nxt  = OVF;
    unique case (act)
      ACT_SET: begin
        q_nxt = MAX_Q;
      end
      ACT_CLR: begin
        q_nxt   = '0;
        ovf_nxt = 1'b0;
      end
      ACT_LOAD: begin
        // Out-of-range load values clamp to the top of the range
        q_nxt = (d_ext > TOP) ? MAX_Q : D;
      end
      ACT_COUNT: begin
        if (term) begin
          tc_r_nxt = 1'b1;
          ovf_nxt  = 1'b1;
        end
        // Saturating counters stay put at the terminal value
        if (!(term && (SATURATE != 0))) begin
          q_nxt = (step > TOP) ? wrap_q : step[WIDTH-1:0];
        end
      end
      default: begin
        q_nxt = Q;
      end
    endcase
  end

  // State registers; reset takes effect immediately, release on CLK
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q    <= RST_Q;
      TC_R <= 1'b0;
      OVF  <= 1'b0;
    end else begin
      Q    <= q_nxt;
      TC_R <= tc_r_nxt;
      OVF  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_syn_counter_mod.sv
// Directed bench for syn_counter_mod: wrap/saturate, up/down, priority,
// clamp, full-range modulus, cascade and asynchronous reset.
module tb_syn_counter_mod;

  logic       clk = 1'b0;
  logic       rst_n;
  // main instance (WIDTH=4, MODULUS=10, wrap)
  logic       en, ci, up, load, sset, sclr;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc, tc_r, ovf;
  // saturating instance
  logic       s_en, s_load;
  logic [3:0] s_d, s_q;
  logic       s_tc, s_tc_r, s_ovf;
  // full-range instance (MODULUS = 2**WIDTH)
  logic       f_en;
  logic [3:0] f_q;
  logic       f_tc, f_tc_r, f_ovf;
  // cascade pair
  logic       c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, lo_tc_r, lo_ovf, hi_tc, hi_tc_r, hi_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  syn_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .CI(ci), .UP(up), .LOAD(load), .D(d),
    .SSET(sset), .SCLR(sclr), .Q(q), .TC(tc), .TC_R(tc_r), .OVF(ovf));

  syn_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VAL(0)) sat (
    .CLK(clk), .RST_N(rst_n), .EN(s_en), .CI(1'b1), .UP(1'b1), .LOAD(s_load), .D(s_d),
    .SSET(1'b0), .SCLR(1'b0), .Q(s_q), .TC(s_tc), .TC_R(s_tc_r), .OVF(s_ovf));

  syn_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .RESET_VAL(0)) full (
    .CLK(clk), .RST_N(rst_n), .EN(f_en), .CI(1'b1), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
    .SSET(1'b0), .SCLR(1'b0), .Q(f_q), .TC(f_tc), .TC_R(f_tc_r), .OVF(f_ovf));

  syn_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) lo (
    .CLK(clk), .RST_N(rst_n), .EN(c_en), .CI(1'b1), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
    .SSET(1'b0), .SCLR(1'b0), .Q(lo_q), .TC(lo_tc), .TC_R(lo_tc_r), .OVF(lo_ovf));

  syn_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) hi (
    .CLK(clk), .RST_N(rst_n), .EN(c_en), .CI(lo_tc), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
    .SSET(1'b0), .SCLR(1'b0), .Q(hi_q), .TC(hi_tc), .TC_R(hi_tc_r), .OVF(hi_ovf));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pre_q[4];
    int post_q[4];
    int s_tcr[4];
    rst_n = 1'b0;
    en = 1'b0; ci = 1'b1; up = 1'b1; load = 1'b0; sset = 1'b0; sclr = 1'b0; d = 4'd0;
    s_en = 1'b0; s_load = 1'b0; s_d = 4'd0; f_en = 1'b0; c_en = 1'b0;

    // Reset state
    #2;
    chk("rst_q", 32'(q), 0);
    chk("rst_tc_r", 32'(tc_r), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_tc", 32'(tc), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: count up 12 edges, wrap at 9
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("up_pre_q", 32'(q), i % 10);
      chk("up_tc", 32'(tc), (i % 10 == 9) ? 1 : 0);
      tick();
      chk("up_q", 32'(q), (i + 1) % 10);
      chk("up_tc_r", 32'(tc_r), (i == 9) ? 1 : 0);
      chk("up_ovf", 32'(ovf), (i >= 9) ? 1 : 0);
    end

    // clear then load 2
    en = 1'b0; sclr = 1'b1;
    tick();
    sclr = 1'b0;
    chk("clr_q", 32'(q), 0);
    chk("clr_ovf", 32'(ovf), 0);
    load = 1'b1; d = 4'd2;
    tick();
    load = 1'b0;
    chk("ld2_q", 32'(q), 2);
    chk("ld2_ovf", 32'(ovf), 0);

    // 2: count down from 2
    pre_q  = '{2, 1, 0, 9};
    post_q = '{1, 0, 9, 8};
    up = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("dn_tc", 32'(tc), (pre_q[i] == 0) ? 1 : 0);
      tick();
      chk("dn_q", 32'(q), post_q[i]);
      chk("dn_tc_r", 32'(tc_r), (pre_q[i] == 0) ? 1 : 0);
      chk("dn_ovf", 32'(ovf), (i >= 2) ? 1 : 0);
    end

    // 3: clamp, priority, clear
    en = 1'b0; up = 1'b1;
    load = 1'b1; d = 4'd13;
    tick();
    chk("clamp_q", 32'(q), 9);
    chk("clamp_ovf", 32'(ovf), 1);
    d = 4'd3; sset = 1'b1; sclr = 1'b1;
    tick();
    chk("sset_win_q", 32'(q), 9);
    chk("sset_ovf", 32'(ovf), 1);
    sset = 1'b0; d = 4'd5;
    tick();
    chk("sclr_win_q", 32'(q), 0);
    chk("sclr_ovf", 32'(ovf), 0);
    sclr = 1'b0; d = 4'd9;
    tick();
    load = 1'b0;
    chk("ld9_q", 32'(q), 9);
    en = 1'b1; ci = 1'b0;
    #1;
    chk("hold_tc_ci0", 32'(tc), 0);
    tick();
    chk("hold_q", 32'(q), 9);
    chk("hold_tc_r", 32'(tc_r), 0);
    ci = 1'b1;
    #1;
    chk("term_tc", 32'(tc), 1);
    en = 1'b0;
    #1;
    chk("term_tc_en0", 32'(tc), 0);

    // full-range modulus: 15 -> 0 with no carry artefact
    f_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk("full_tc", 32'(f_tc), (i == 15) ? 1 : 0);
      tick();
      chk("full_q", 32'(f_q), (i + 1) % 16);
      chk("full_tc_r", 32'(f_tc_r), (i == 15) ? 1 : 0);
    end
    f_en = 1'b0;

    // 4: saturate from 8
    s_tcr = '{0, 1, 1, 1};
    s_load = 1'b1; s_d = 4'd8;
    tick();
    s_load = 1'b0;
    chk("sat_ld_q", 32'(s_q), 8);
    s_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sat_q", 32'(s_q), 9);
      chk("sat_tc_r", 32'(s_tc_r), s_tcr[i]);
      chk("sat_ovf", 32'(s_ovf), s_tcr[i]);
    end
    s_en = 1'b0;
    tick();
    chk("sat_idle_tc_r", 32'(s_tc_r), 0);

    // 5: cascade, 25 edges
    c_en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      chk("cas_lo", 32'(lo_q), (k + 1) % 10);
      chk("cas_hi", 32'(hi_q), (k + 1) / 10);
    end
    c_en = 1'b0;

    // 6: asynchronous reset mid-count at Q=7 with OVF set
    en = 1'b1;
    tick();
    chk("pre_rst_q", 32'(q), 0);
    chk("pre_rst_ovf", 32'(ovf), 1);
    en = 1'b0; load = 1'b1; d = 4'd7;
    tick();
    load = 1'b0;
    chk("q7", 32'(q), 7);
    en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q", 32'(q), 0);
    chk("arst_ovf", 32'(ovf), 0);
    chk("arst_tc_r", 32'(tc_r), 0);
    tick();
    chk("arst_hold_q", 32'(q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_q", 32'(q), 0);
    tick();
    chk("rel_count_q", 32'(q), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
